// File: rtl/uart_tx_frame_fsm_if.sv
// rtl/uart_tx_frame_fsm_if.sv - word handshake between a producer and uart_tx_frame_fsm
interface uart_tx_frame_fsm_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_frame_fsm.sv
// rtl/uart_tx_frame_fsm.sv - UART transmit frame sequencer and serial datapath, one bit per fsm_clk
// Optional UART_TX_BREAK_EN adds a tx_break input that holds the line low and aborts any frame.
module uart_tx_frame_fsm #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic               fsm_clk,
    input  logic               rst,
    input  logic               tx_enable,
`ifdef UART_TX_BREAK_EN
    input  logic               tx_break,
`endif
    uart_tx_frame_fsm_if.slave s_if,
    output logic               tx,
    output logic               busy,
    output logic               tx_done
);
    localparam int CNT_MAX = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic PAR_INV = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state, state_d;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_d;
    logic                 done_d;
    logic                 brk;
    logic                 last_stop;
    logic                 xfer;

`ifdef UART_TX_BREAK_EN
    assign brk = tx_break;
`else
    assign brk = 1'b0;
`endif

    assign last_stop = (state == STOP) && (bit_cnt == STOP_LAST);
    assign xfer      = s_if.tx_valid && s_if.tx_ready;
    assign busy      = (state != IDLE) || brk;

    always_ff @(posedge fsm_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx       <= tx_d;
            tx_done  <= done_d;
        end
    end

    // Capture happens from IDLE or the last stop cycle, giving zero-gap back-to-back frames.
    always_comb begin
        state_d   = state;
        bit_cnt_d = bit_cnt;
        shift_d   = shift_q;
        parity_d  = parity_q;
        if (!tx_enable || brk) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            shift_d   = '0;
            parity_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        state_d  = START;
                        shift_d  = s_if.tx_data;
                        parity_d = (^s_if.tx_data) ^ PAR_INV;
                    end
                end
                START: begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
                DATA: begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
                STOP: begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_cnt_d = '0;
                        if (xfer) begin
                            state_d  = START;
                            shift_d  = s_if.tx_data;
                            parity_d = (^s_if.tx_data) ^ PAR_INV;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
                default: begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                end
            endcase
        end
    end

    // The line value for the current state is registered, so tx trails state by one cycle.
    always_comb begin
        s_if.tx_ready = tx_enable && !brk && ((state == IDLE) || last_stop);
        tx_d          = 1'b1;
        done_d        = 1'b0;
        if (brk) begin
            tx_d = 1'b0;
        end else if (tx_enable) begin
            case (state)
                START:   tx_d = 1'b0;
                DATA:    tx_d = shift_q[0];
                PARITY:  tx_d = parity_q;
                default: tx_d = 1'b1;
            endcase
            done_d = last_stop;
        end
    end
endmodule

// File: doc/uart_tx_frame_fsm.md
Name: uart_tx_frame_fsm

Overview:
Parametrised UART transmit engine that combines frame sequencing and the serial datapath in one block. Configurable data width, optional parity and stop-bit count. One bit is emitted per fsm_clk cycle; fsm_clk is the baud-rate clock from the existing baud generator. It accepts words over a valid/ready handshake and supports back-to-back frames with no idle gap.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY_EN, 0, 1 = append one parity bit after the data bits
PARITY_ODD, 0, with PARITY_EN=1: 0 = even parity, 1 = odd parity
STOP_BITS, 1, stop bits per frame; legal 1..2

Ports:
fsm_clk  input  1  baud-rate clock; all state changes on its rising edge
rst  input  1  asynchronous, active-high reset
tx_enable  input  1  synchronous enable; low forces IDLE
tx_data  input  DATA_BITS  word to send; sampled only on handshake
tx_valid  input  1  tx_data is valid
tx_ready  output  1  block can accept a word this cycle
tx  output  1  serial line; idles high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse after the final stop bit

Behaviour:
- Reset values: state IDLE, tx=1, busy=0, tx_done=0, shift register=0, bit counter=0. tx_ready follows the combinational rule below.
- tx is a registered output (glitch-free line).
- States: IDLE, START, DATA, PARITY, STOP.
- tx_ready = tx_enable && (state==IDLE || (state==STOP && last stop bit)). Combinational.
- Handshake: a transfer occurs on any rising edge with tx_valid && tx_ready. tx_data is captured into the shift register and parity is computed from tx_data at capture time.
- IDLE: on transfer, go to START. Otherwise stay; tx=1.
- START: tx=0 for 1 cycle, then DATA.
- DATA: LSB first, one bit per cycle, for DATA_BITS cycles. The bit counter runs 0..DATA_BITS-1. Next state is PARITY if PARITY_EN=1, else STOP.
- PARITY: tx = XOR of the data bits, inverted when PARITY_ODD=1. Lasts 1 cycle, then STOP.
- STOP: tx=1 for STOP_BITS cycles. On the last stop cycle:
  - If a transfer occurs, go directly to START (zero-gap back-to-back).
  - Otherwise go to IDLE.
- Frame length: 1 + DATA_BITS + PARITY_EN + STOP_BITS cycles.
- Latency: tx falls on the first edge after the accepting edge.
- tx_done: registered. High for exactly 1 cycle, in the cycle after the last stop bit completes. This holds in both the back-to-back and return-to-IDLE cases.
- busy = (state != IDLE).
- tx_enable low in any state:
  - Next edge: state IDLE, tx=1, counters cleared, no tx_done.
  - The in-flight word is dropped.
  - tx_ready=0 while tx_enable is low.
- Reset asserted mid-frame: immediate return to reset values, regardless of clock.
- tx_valid dropping without a handshake has no effect. tx_data changes after capture have no effect.
- Bit counter is sized for max(DATA_BITS, STOP_BITS). It never wraps mid-frame.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input tx_break (1 bit).
  - While tx_break=1, tx is forced to 0 from the next edge.
  - tx_ready=0 and busy=1 while tx_break=1.
  - Break asserted mid-frame aborts the frame to IDLE (no tx_done). The line stays low until tx_break deasserts.
  - After deassertion, tx=1 for at least one cycle in IDLE before a new START.
- Undefined: no tx_break port; behaviour exactly as above.

Test Plan:
- Default params, tx_data=8'hA5 handshake -> tx sequence 0,1,0,1,0,0,1,0,1,1; busy high for 10 cycles; tx_done one pulse on cycle 11; tx_ready high again on the last stop cycle.
- PARITY_EN=1, PARITY_ODD=0, data 8'h07 -> parity bit 1. With PARITY_ODD=1, same data -> parity bit 0. Frame length 11 cycles.
- DATA_BITS=5, STOP_BITS=2, tx_valid held high with words 5'h1F then 5'h00 -> second START immediately follows the second stop bit, no idle cycle; tx_done pulses twice, 8 cycles apart.
- tx_enable dropped during DATA bit 3 of 8'hFF -> next edge tx=1, busy=0, no tx_done. Re-enable plus new handshake -> complete clean frame.
- rst pulsed asynchronously mid-STOP (not on a clock edge) -> tx=1, busy=0, tx_done=0 immediately. The next handshake after release sends a normal frame.
- UART_TX_BREAK_EN defined: tx_break high for 20 cycles during DATA -> tx=0 for those cycles, tx_ready=0, no tx_done. After release, tx=1 for ≥1 cycle before the next START.
